// File: rtl/yutorina_ex_stage.sv
// Execute stage of the Yutorina pipeline: operand forwarding, the ALU, and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module yutorina_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_OP_WIDTH   = 3,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [ALU_OP_WIDTH-1:0]   id_alu_opcode,
  input  logic [DATA_WIDTH-1:0]     id_lhs,
  input  logic [DATA_WIDTH-1:0]     id_rhs,
  input  logic [REG_ADDR_WIDTH-1:0] id_lhs_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rhs_addr,
  input  logic                      id_rhs_is_reg,
  input  logic [REG_ADDR_WIDTH-1:0] id_dst_addr,
  input  logic                      id_gpr_we,
  input  logic                      mem_gpr_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_dst_addr,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  output logic                      ex_valid,
  output logic [DATA_WIDTH-1:0]     ex_result,
  output logic [REG_ADDR_WIDTH-1:0] ex_dst_addr,
  output logic                      ex_gpr_we
);

  // Valid semantics: ex_valid marks a real instruction in EX/MEM; there is no
  // ready path, stall freezes the register and flush replaces it with a bubble.

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LSH = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_RSH = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LT  = ALU_OP_WIDTH'(7);
  localparam logic [DATA_WIDTH-1:0]   SHIFT_LIMIT = DATA_WIDTH'(DATA_WIDTH);

  logic                  lhs_ex_hit, lhs_mem_hit, rhs_ex_hit, rhs_mem_hit;
  logic [DATA_WIDTH-1:0] fwd_lhs, fwd_rhs, alu_result;

  // EX is younger than MEM, so its result takes priority; r0 is never forwarded.
  assign lhs_ex_hit  = ex_valid && ex_gpr_we && (ex_dst_addr == id_lhs_addr) && (id_lhs_addr != '0);
  assign lhs_mem_hit = mem_gpr_we && (mem_dst_addr == id_lhs_addr) && (id_lhs_addr != '0);
  assign rhs_ex_hit  = id_rhs_is_reg && ex_valid && ex_gpr_we &&
                       (ex_dst_addr == id_rhs_addr) && (id_rhs_addr != '0);
  assign rhs_mem_hit = id_rhs_is_reg && mem_gpr_we &&
                       (mem_dst_addr == id_rhs_addr) && (id_rhs_addr != '0);

  always_comb begin
    fwd_lhs = id_lhs;
    if (lhs_ex_hit)       fwd_lhs = ex_result;
    else if (lhs_mem_hit) fwd_lhs = mem_data;
    fwd_rhs = id_rhs;
    if (rhs_ex_hit)       fwd_rhs = ex_result;
    else if (rhs_mem_hit) fwd_rhs = mem_data;
  end

  always_comb begin
    alu_result = '0;
    case (id_alu_opcode)
      OP_ADD: alu_result = fwd_lhs + fwd_rhs;
      OP_SUB: alu_result = fwd_lhs - fwd_rhs;
      OP_AND: alu_result = fwd_lhs & fwd_rhs;
      OP_OR:  alu_result = fwd_lhs | fwd_rhs;
      OP_XOR: alu_result = fwd_lhs ^ fwd_rhs;
      OP_LSH: alu_result = (fwd_rhs >= SHIFT_LIMIT) ? '0 : (fwd_lhs << fwd_rhs);
      OP_RSH: alu_result = (fwd_rhs >= SHIFT_LIMIT) ? '0 : (fwd_lhs >> fwd_rhs);
      OP_LT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (fwd_lhs < fwd_rhs)};
      default: alu_result = '0;
    endcase
  end

  // Bubbles keep the last result/destination; only valid and write enable drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_result   <= '0;
      ex_dst_addr <= '0;
      ex_gpr_we   <= 1'b0;
    end else if (flush) begin
      ex_valid  <= 1'b0;
      ex_gpr_we <= 1'b0;
    end else if (!stall) begin
      if (id_valid) begin
        ex_valid    <= 1'b1;
        ex_result   <= alu_result;
        ex_dst_addr <= id_dst_addr;
        ex_gpr_we   <= id_gpr_we;
      end else begin
        ex_valid  <= 1'b0;
        ex_gpr_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_yutorina_ex_stage.sv
// Bench for yutorina_ex_stage: directed vectors, a behavioural reference model
// and literal expectations, all checked by one compare process on the falling edge.
module tb_yutorina_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [2:0]  id_alu_opcode;
  logic [31:0] id_lhs, id_rhs, mem_data;
  logic [4:0]  id_lhs_addr, id_rhs_addr, id_dst_addr, mem_dst_addr;
  logic        id_rhs_is_reg, id_gpr_we, mem_gpr_we;
  logic        ex_valid, ex_gpr_we;
  logic [31:0] ex_result;
  logic [4:0]  ex_dst_addr;

  yutorina_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_alu_opcode(id_alu_opcode), .id_lhs(id_lhs), .id_rhs(id_rhs),
    .id_lhs_addr(id_lhs_addr), .id_rhs_addr(id_rhs_addr), .id_rhs_is_reg(id_rhs_is_reg),
    .id_dst_addr(id_dst_addr), .id_gpr_we(id_gpr_we), .mem_gpr_we(mem_gpr_we),
    .mem_dst_addr(mem_dst_addr), .mem_data(mem_data), .ex_valid(ex_valid),
    .ex_result(ex_result), .ex_dst_addr(ex_dst_addr), .ex_gpr_we(ex_gpr_we)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_valid, m_we;
  logic [31:0] m_result;
  logic [4:0]  m_dst;

  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] raw,
                                          input logic is_reg);
    if (!is_reg || src == 5'd0) return raw;
    if (m_valid && m_we && m_dst == src) return m_result;
    if (mem_gpr_we && mem_dst_addr == src) return mem_data;
    return raw;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    longint unsigned la, lb;
    la = 64'(a);
    lb = 64'(b);
    case (op)
      3'd0: return 32'(la + lb);
      3'd1: return 32'(la + 64'h1_0000_0000 - lb);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (lb >= 32) ? 32'd0 : 32'(la * (64'd1 << lb));
      3'd6: return (lb >= 32) ? 32'd0 : 32'(la / (64'd1 << lb));
      default: return (la < lb) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0; m_we <= 1'b0; m_result <= 32'd0; m_dst <= 5'd0;
    end else if (flush) begin
      m_valid <= 1'b0; m_we <= 1'b0;
    end else if (!stall) begin
      m_valid <= id_valid;
      m_we    <= id_valid && id_gpr_we;
      if (id_valid) begin
        m_result <= alu(id_alu_opcode, operand(id_lhs_addr, id_lhs, 1'b1),
                        operand(id_rhs_addr, id_rhs, id_rhs_is_reg));
        m_dst    <= id_dst_addr;
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Literal expectations packed as {valid, we, dst[4:0], result[31:0]}.
  logic [38:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        started = 1'b0;
  int          cyc = 0;

  always @(negedge clk) begin
    if (started) begin
      cyc <= cyc + 1;
      n_checks = n_checks + 1;
      if ({ex_valid, ex_gpr_we, ex_dst_addr, ex_result} !== {m_valid, m_we, m_dst, m_result}) begin
        n_errors = n_errors + 1;
        $display("FAIL model cyc=%0d got v=%b we=%b dst=%0d res=%h exp v=%b we=%b dst=%0d res=%h",
                 cyc, ex_valid, ex_gpr_we, ex_dst_addr, ex_result, m_valid, m_we, m_dst, m_result);
      end
      if (exp_q.size() > 0) begin
        logic [38:0] e;
        e = exp_q.pop_front();
        n_checks = n_checks + 1;
        if ({ex_valid, ex_gpr_we, ex_dst_addr, ex_result} !== e) begin
          n_errors = n_errors + 1;
          $display("FAIL literal cyc=%0d got v=%b we=%b dst=%0d res=%h exp v=%b we=%b dst=%0d res=%h",
                   cyc, ex_valid, ex_gpr_we, ex_dst_addr, ex_result, e[38], e[37], e[36:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic has_exp, input logic v, input logic we,
                      input logic [4:0] dst, input logic [31:0] res);
    if (has_exp) exp_q.push_back({v, we, dst, res});
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] dst, input logic we);
    id_valid = 1'b1; id_alu_opcode = op; id_lhs = a; id_rhs = b;
    id_lhs_addr = 5'd0; id_rhs_addr = 5'd0; id_rhs_is_reg = 1'b0;
    id_dst_addr = dst; id_gpr_we = we;
  endtask

  task automatic randomize_id();
    id_valid = 1'b1; id_alu_opcode = 3'($urandom_range(0, 7));
    id_lhs = $urandom; id_rhs = $urandom;
    id_lhs_addr = 5'($urandom_range(0, 31)); id_rhs_addr = 5'($urandom_range(0, 31));
    id_rhs_is_reg = 1'($urandom_range(0, 1)); id_dst_addr = 5'($urandom_range(0, 31));
    id_gpr_we = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
    randomize_id();
    mem_gpr_we = 1'($urandom_range(0, 1)); mem_dst_addr = 5'($urandom_range(0, 31));
    mem_data = $urandom;
    @(posedge clk); #1;
    started = 1'b1;
    exp_q.push_back(39'd0);
    randomize_id();
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);

    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_gpr_we = 1'b0; mem_dst_addr = 5'd0; mem_data = 32'd0;
    set_op(3'd0, 32'd3, 32'd4, 5'd5, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd5, 32'd7);

    set_op(3'd1, 32'd0, 32'd1, 5'd5, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd5, 32'hFFFF_FFFF);
    set_op(3'd5, 32'd1, 32'd32, 5'd5, 1'b1);              step(1'b1, 1'b1, 1'b1, 5'd5, 32'd0);
    set_op(3'd6, 32'h8000_0000, 32'd31, 5'd5, 1'b1);      step(1'b1, 1'b1, 1'b1, 5'd5, 32'd1);
    set_op(3'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1);       step(1'b1, 1'b1, 1'b1, 5'd5, 32'd0);
    set_op(3'd7, 32'd1, 32'd2, 5'd5, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd5, 32'd1);
    set_op(3'd5, 32'h0000_00F1, 32'd4, 5'd5, 1'b1);       step(1'b1, 1'b1, 1'b1, 5'd5, 32'h0000_0F10);

    // EX beats MEM for the same source register
    set_op(3'd0, 32'd2, 32'd3, 5'd1, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd1, 32'd5);
    set_op(3'd0, 32'd0, 32'd0, 5'd2, 1'b1);
    id_lhs_addr = 5'd1; id_rhs_addr = 5'd1; id_rhs_is_reg = 1'b1;
    mem_gpr_we = 1'b1; mem_dst_addr = 5'd1; mem_data = 32'd9;
    step(1'b1, 1'b1, 1'b1, 5'd2, 32'd10);
    // MEM-only hit on lhs
    set_op(3'd3, 32'd0, 32'd6, 5'd7, 1'b1); id_lhs_addr = 5'd1;
    step(1'b1, 1'b1, 1'b1, 5'd7, 32'd15);
    mem_gpr_we = 1'b0;

    // r0 is never forwarded
    set_op(3'd0, 32'd3, 32'd4, 5'd0, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd0, 32'd7);
    set_op(3'd0, 32'd0, 32'd1, 5'd4, 1'b1);               step(1'b1, 1'b1, 1'b1, 5'd4, 32'd1);
    // immediate rhs whose address matches the EX destination
    set_op(3'd0, 32'd10, 32'd20, 5'd3, 1'b1);             step(1'b1, 1'b1, 1'b1, 5'd3, 32'd30);
    set_op(3'd0, 32'd1, 32'd2, 5'd8, 1'b1); id_rhs_addr = 5'd3;
    step(1'b1, 1'b1, 1'b1, 5'd8, 32'd3);
    // register rhs forwarded from EX
    set_op(3'd2, 32'hFF, 32'd0, 5'd9, 1'b1); id_rhs_addr = 5'd8; id_rhs_is_reg = 1'b1;
    step(1'b1, 1'b1, 1'b1, 5'd9, 32'd3);
    // an instruction without write enable is not a forwarding source
    set_op(3'd0, 32'd5, 32'd5, 5'd10, 1'b0);              step(1'b1, 1'b1, 1'b0, 5'd10, 32'd10);
    set_op(3'd0, 32'd1, 32'd1, 5'd11, 1'b1); id_lhs_addr = 5'd10;
    step(1'b1, 1'b1, 1'b1, 5'd11, 32'd2);

    // stall freezes outputs while ID inputs keep changing
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_id();
      step(1'b1, 1'b1, 1'b1, 5'd11, 32'd2);
    end
    stall = 1'b0;
    set_op(3'd4, 32'hF0, 32'hFF, 5'd6, 1'b1);             step(1'b1, 1'b1, 1'b1, 5'd6, 32'h0F);

    // flush beats stall; bubble keeps result and destination
    stall = 1'b1; flush = 1'b1;
    set_op(3'd0, 32'd100, 32'd1, 5'd13, 1'b1);            step(1'b1, 1'b0, 1'b0, 5'd6, 32'h0F);
    stall = 1'b0; flush = 1'b0;
    id_valid = 1'b0;                                      step(1'b1, 1'b0, 1'b0, 5'd6, 32'h0F);
    set_op(3'd0, 32'd1, 32'd1, 5'd12, 1'b1);              step(1'b1, 1'b1, 1'b1, 5'd12, 32'd2);
    flush = 1'b1;
    set_op(3'd0, 32'd7, 32'd7, 5'd14, 1'b1);              step(1'b1, 1'b0, 1'b0, 5'd12, 32'd2);
    flush = 1'b0;
    set_op(3'd1, 32'd9, 32'd4, 5'd15, 1'b1);              step(1'b1, 1'b1, 1'b1, 5'd15, 32'd5);

    // reset while stalled clears everything on that edge
    stall = 1'b1; reset = 1'b1;
    randomize_id();                                       step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    stall = 1'b0; reset = 1'b0;
    set_op(3'd0, 32'd20, 32'd22, 5'd16, 1'b1);            step(1'b1, 1'b1, 1'b1, 5'd16, 32'd42);
    id_valid = 1'b0;
    step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
